// File: rtl/ce_pkg.sv
// ce_pkg: shared helpers for the convolution-engine window generator and
// the CE_net benches.
//   k2(kernel)          -> kernel*kernel, number of taps in one channel plane
//   clog2(v)            -> counter/pointer width for a range of v values (min 1)
//   idx(c, r, k, kernel)-> flat sample index of channel c, row r, column k
//                          inside a packed window (multiply by N for bits)
package ce_pkg;

  function automatic int k2(input int kernel);
    return kernel * kernel;
  endfunction

  // Width able to hold 0..v-1; never returns 0 so degenerate sizes still
  // produce a legal vector.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // r=0 is the oldest (top) row, k=0 the oldest (leftmost) column.
  function automatic int idx(input int c, input int r, input int k, input int kernel);
    return (c * kernel + r) * kernel + k;
  endfunction

endpackage

// File: rtl/ce_line_buf.sv
// ce_line_buf: one image-row delay line. Every enabled cycle the sample
// written IMG_W enabled cycles ago is presented on dout (combinational read)
// and din takes its place, so the delay counts accepted pixels, not clocks.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset (clears the pointer only)
//   en    advance the line (accepted pixel)
//   din   sample entering the line
//   dout  sample leaving the line (DEPTH accepted samples old)
module ce_line_buf
  import ce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // The slot about to be overwritten holds the oldest sample.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; the window gating hides stale rows.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/ce_window_gen.sv
// ce_window_gen: streaming front end of the convolution engine. Takes one
// CL_IN-channel pixel per cycle in raster order, keeps KERNEL-1 rows in
// cascaded line buffers and emits each valid KERNEL x KERNEL x CL_IN window
// (no padding) to CE_net one cycle after the completing pixel is accepted.
// Build option: define CE_WIN_STRIDE2_EN to emit only the stride-2 windows.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   pix_in     one pixel, channel c at [c*N +: N]
//   pix_valid  pixel accepted on this edge
//   sof        start of frame, forces the accepted pixel to (0,0)
//   data2conv  window, sample (c,r,k) at [idx(c,r,k)*N +: N]
//   en_out     one-cycle strobe, data2conv carries a new window
//   frame_done one-cycle pulse after the last pixel of a frame
module ce_window_gen
  import ce_pkg::*;
#(
  parameter int CL_IN  = 1,
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CL_IN*N-1:0]            pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
  output logic                          en_out,
  output logic                          frame_done
);

  localparam int K2 = k2(KERNEL);
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam int PW = CL_IN * N;
  localparam int WW = CL_IN * K2 * N;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);

  logic [CW-1:0] col, cur_col, nxt_col;
  logic [RW-1:0] row, cur_row, nxt_row;
  logic          emit, last_pix, stride_ok;

  // tap[j] is the pixel j rows older than pix_in.
  logic [KERNEL-1:0][PW-1:0] tap;
  logic [WW-1:0]             win_p0, win_nxt;
  logic [WW-1:0]             data_p1;
  logic                      vld_p1, done_p1;

  assign tap[0] = pix_in;

  for (genvar i = 0; i < KERNEL - 1; i++) begin : g_lb
    ce_line_buf #(
      .WIDTH(PW),
      .DEPTH(IMG_W)
    ) u_lb (
      .clk (clk),
      .rst (rst),
      .en  (pix_valid),
      .din (tap[i]),
      .dout(tap[i+1])
    );
  end

  // sof re-labels the incoming pixel as (0,0) before any decision is made.
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    nxt_col = cur_col + 1'b1;
    nxt_row = cur_row;
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
  end

`ifdef CE_WIN_STRIDE2_EN
  // KERNEL is odd, so an even offset from KERNEL-1 means matching parity.
  localparam logic KPAR = 1'((KERNEL - 1) % 2);
  assign stride_ok = (cur_row[0] == KPAR) && (cur_col[0] == KPAR);
`else
  assign stride_ok = 1'b1;
`endif

  assign emit = pix_valid && (cur_row >= ROW_K) && (cur_col >= COL_K) && stride_ok;
  // Uses the un-resynced position so a sof landing on the last pixel still
  // closes the old frame.
  assign last_pix = pix_valid && (row == ROW_LAST) && (col == COL_LAST);

  // Shift the window one column left and load {line taps, pix_in} on the right.
  always_comb begin
    win_nxt = win_p0;
    for (int c = 0; c < CL_IN; c++) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL; k++) begin
          if (k < KERNEL - 1)
            win_nxt[idx(c, r, k, KERNEL)*N +: N] = win_p0[idx(c, r, k + 1, KERNEL)*N +: N];
          else
            win_nxt[idx(c, r, k, KERNEL)*N +: N] = tap[KERNEL-1-r][c*N +: N];
        end
      end
    end
  end

  // ---- stage p0: window register, advances only on accepted pixels ----
  always_ff @(posedge clk) begin
    if (pix_valid) win_p0 <= win_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // ---- stage p1: output register, holds the last emitted window ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= emit;
      done_p1 <= last_pix;
      if (emit) data_p1 <= win_nxt;
    end
  end

  assign data2conv  = data_p1;
  assign en_out     = vld_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_ce_window_gen.sv
// Directed bench for ce_window_gen with CL_IN=1, KERNEL=3, N=4, 5x5 image,
// pixel value (row*5+col) mod 16. Honours CE_WIN_STRIDE2_EN when defined.
module tb_ce_window_gen;

  localparam int CL_IN = 1;
  localparam int K     = 3;
  localparam int N     = 4;
  localparam int W     = 5;
  localparam int H     = 5;
  localparam int DW    = CL_IN * K * K * N;

`ifdef CE_WIN_STRIDE2_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 9;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  pix_in;
  logic          pix_valid;
  logic          sof;
  logic [DW-1:0] data2conv;
  logic          en_out;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int npulse  = 0;
  logic [DW-1:0] exp_data = '0;

  ce_window_gen #(
    .CL_IN (CL_IN),
    .KERNEL(K),
    .N     (N),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .data2conv (data2conv),
    .en_out    (en_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pv(input int r, input int c);
    return N'((r * W + c) % 16);
  endfunction

  function automatic logic [DW-1:0] win_model(input int r, input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int rr = 0; rr < K; rr++)
      for (int k = 0; k < K; k++)
        w[(rr*K + k)*N +: N] = pv(r - (K-1) + rr, c - (K-1) + k);
    return w;
  endfunction

  function automatic bit win_expected(input int r, input int c);
    bit e;
    e = (r >= K-1) && (c >= K-1);
`ifdef CE_WIN_STRIDE2_EN
    e = e && ((r - (K-1)) % 2 == 0) && ((c - (K-1)) % 2 == 0);
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present pixel (r,c) of the current frame and check the cycle after.
  task automatic px(input int r, input int c, input bit s, input bit force_done);
    bit e;
    pix_in    = pv(r, c);
    pix_valid = 1'b1;
    sof       = s;
    tick();
    pix_valid = 1'b0;
    sof       = 1'b0;
    e = win_expected(r, c);
    if (e) begin
      exp_data = win_model(r, c);
      npulse++;
    end
    chk("en_out", 64'(en_out), 64'(e));
    chk("data2conv", 64'(data2conv), 64'(exp_data));
    chk("frame_done", 64'(frame_done), 64'(((r == H-1) && (c == W-1)) || force_done));
  endtask

  task automatic idle();
    pix_in    = N'($urandom);
    pix_valid = 1'b0;
    tick();
    chk("idle_en", 64'(en_out), 64'd0);
    chk("idle_hold", 64'(data2conv), 64'(exp_data));
    chk("idle_done", 64'(frame_done), 64'd0);
  endtask

  initial begin
    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
    tick(); tick();
    chk("rst_en", 64'(en_out), 64'd0);
    chk("rst_data", 64'(data2conv), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    rst = 1'b1;

    // Basic frame with continuous valid.
    npulse = 0;
    for (int p = 0; p < W*H; p++) begin
      px(p / W, p % W, p == 0, 1'b0);
      if (p == 12) chk("first_win", 64'(data2conv), 64'h0_CBA7_6521_0);
      if (p == 24) chk("last_win", 64'(data2conv), 64'h8_7632_1EDC);
    end
    chk("basic_npulse", 64'(npulse), 64'(NWIN));
    idle(); idle();

    // Alternating valid/gap: same windows, never back-to-back strobes.
    npulse = 0;
    for (int p = 0; p < W*H; p++) begin
      px(p / W, p % W, p == 0, 1'b0);
      idle();
    end
    chk("gap_npulse", 64'(npulse), 64'(NWIN));

    // Reset in the middle of a frame, then a fresh frame without sof.
    for (int p = 0; p < 15; p++) px(p / W, p % W, p == 0, 1'b0);
    rst = 1'b0;
    tick();
    exp_data = '0;
    chk("midrst_en", 64'(en_out), 64'd0);
    chk("midrst_data", 64'(data2conv), 64'd0);
    chk("midrst_done", 64'(frame_done), 64'd0);
    rst = 1'b1;
    npulse = 0;
    for (int p = 0; p < W*H; p++) begin
      px(p / W, p % W, 1'b0, 1'b0);
      if (p == 12) chk("post_rst_first", 64'(data2conv), 64'h0_CBA7_6521_0);
    end
    chk("post_rst_npulse", 64'(npulse), 64'(NWIN));

    // Resync: sof arrives at old position row 3, col 1.
    for (int p = 0; p < 16; p++) px(p / W, p % W, p == 0, 1'b0);
    npulse = 0;
    for (int p = 0; p < W*H; p++) px(p / W, p % W, p == 0, 1'b0);
    chk("resync_npulse", 64'(npulse), 64'(NWIN));

    // sof exactly on the last pixel still reports frame_done.
    for (int p = 0; p < W*H - 1; p++) px(p / W, p % W, p == 0, 1'b0);
    npulse = 0;
    px(0, 0, 1'b1, 1'b1);
    for (int p = 1; p < W*H; p++) px(p / W, p % W, 1'b0, 1'b0);
    chk("sof_last_npulse", 64'(npulse), 64'(NWIN));
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
